// File: rtl/aether_mem_arb_pkg.sv
// Shared types and constants for the memory arbiter that fronts a single
// generic memory instance.
package aether_mem_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_READ    = 2'd2,
        CMD_INVALID = 2'd3
    } mem_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_COOL  = 3'd4
    } arb_state_e;

    // Round-robin successor of idx among n requesters.
    function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of valid_i at or after
// ptr_i, wrapping to the lowest set bit when none lies at or above ptr_i.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] hi_idx_s;
    logic [IW-1:0] lo_idx_s;
    logic          hi_found_s;
    logic          lo_found_s;
    logic          hi_hit_s;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_hit_s   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            hi_hit_s   = valid_i[i] && (32'(i) >= 32'(ptr_i));
            lo_idx_s   = valid_i[i] ? IW'(i) : lo_idx_s;
            lo_found_s = lo_found_s | valid_i[i];
            hi_idx_s   = hi_hit_s ? IW'(i) : hi_idx_s;
            hi_found_s = hi_found_s | hi_hit_s;
        end
    end

    // Prefer the wrap-free candidate; fall back to the lowest one.
    always_comb begin
        found_o = lo_found_s;
        idx_o   = hi_found_s ? hi_idx_s : lo_idx_s;
        grant_o = lo_found_s ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/aether_engine_mem_arbiter.sv
// Task-granular round-robin arbiter sharing one generic memory between
// NumReq requesters; resets the memory between tasks to clear stale status.
module aether_engine_mem_arbiter
    import aether_mem_arb_pkg::*;
#(
    parameter int NumReq  = 2,
    parameter int ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_i,
    input  logic [2*NumReq-1:0]        cmd_i,
    input  logic [ADDR_W*NumReq-1:0]   start_addr_i,
    input  logic [ADDR_W*NumReq-1:0]   end_addr_i,
    input  logic [DATA_W*NumReq-1:0]   wdata_i,
    input  logic [NumReq-1:0]          wvalid_i,
    output logic [NumReq-1:0]          grant_o,
    output logic [ReqIdxW-1:0]         grant_idx_o,
    output logic [NumReq-1:0]          wready_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [NumReq-1:0]          rvalid_o,
    output logic [NumReq-1:0]          done_o,
    output logic [NumReq-1:0]          err_o,
    output logic                       mem_rst_o,
    output logic                       mem_en_o,
    output logic [1:0]                 mem_command_o,
    output logic [ADDR_W-1:0]          mem_start_o,
    output logic [ADDR_W-1:0]          mem_end_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    input  logic                       mem_rvalid_i,
    input  logic                       mem_wready_i,
    input  logic                       mem_finished_i,
    input  logic                       mem_running_i
);

    arb_state_e           state_q;
    logic [ReqIdxW-1:0]   rr_ptr_q;
    logic [NumReq-1:0]    grant_q;
    logic [ReqIdxW-1:0]   grant_idx_q;
    mem_cmd_e             cmd_q;
    mem_cmd_e             mem_cmd_q;
    logic [ADDR_W-1:0]    start_q;
    logic [ADDR_W-1:0]    end_q;
    logic [NumReq-1:0]    done_q;
    logic [NumReq-1:0]    err_q;
    logic                 mem_rst_q;

    mem_cmd_e             req_cmd_s   [NumReq];
    logic [ADDR_W-1:0]    req_start_s [NumReq];
    logic [ADDR_W-1:0]    req_end_s   [NumReq];
    logic [DATA_W-1:0]    req_wdata_s [NumReq];
    logic [NumReq-1:0]    cand_s;
    logic [NumReq-1:0]    inv_s;
    logic [NumReq-1:0]    pick_grant_s;
    logic [ReqIdxW-1:0]   pick_idx_s;
    logic                 pick_found_s;
    logic                 run_write_s;
    logic                 run_read_s;
    logic                 beat_s;

    // Unpack per-requester buses and classify each request.
    always_comb begin
        cand_s = '0;
        inv_s  = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_cmd_s[i]   = mem_cmd_e'(cmd_i[2*i +: 2]);
            req_start_s[i] = start_addr_i[ADDR_W*i +: ADDR_W];
            req_end_s[i]   = end_addr_i[ADDR_W*i +: ADDR_W];
            req_wdata_s[i] = wdata_i[DATA_W*i +: DATA_W];
            cand_s[i]      = req_i[i] && (req_cmd_s[i] == CMD_WRITE || req_cmd_s[i] == CMD_READ);
            inv_s[i]       = req_i[i] && (req_cmd_s[i] == CMD_INVALID);
        end
    end

    rr_picker #(
        .N  (NumReq),
        .IW (ReqIdxW)
    ) u_picker (
        .valid_i (cand_s),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .found_o (pick_found_s)
    );

    // Task sequencer: grant, one-cycle command, run, memory flush, cool-down.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            cmd_q       <= CMD_IDLE;
            mem_cmd_q   <= CMD_IDLE;
            start_q     <= '0;
            end_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            mem_rst_q   <= 1'b0;
        end else begin
            done_q    <= '0;
            err_q     <= '0;
            mem_rst_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_q <= inv_s;
                    if (pick_found_s) begin
                        grant_q     <= pick_grant_s;
                        grant_idx_q <= pick_idx_s;
                        cmd_q       <= req_cmd_s[pick_idx_s];
                        mem_cmd_q   <= req_cmd_s[pick_idx_s];
                        start_q     <= req_start_s[pick_idx_s];
                        end_q       <= req_end_s[pick_idx_s];
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_cmd_q <= CMD_IDLE;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (mem_finished_i) begin
                        mem_rst_q <= 1'b1;
                        done_q    <= grant_q;
                        state_q   <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    rr_ptr_q <= ReqIdxW'(rr_next(32'(grant_idx_q), 32'(NumReq)));
                    state_q  <= ST_COOL;
                end
                ST_COOL: begin
                    // Hold the grant until the memory has fully quiesced.
                    if (!mem_running_i && !mem_finished_i) begin
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data-path steering toward the current owner during RUN.
    always_comb begin
        run_write_s   = (state_q == ST_RUN) && (cmd_q == CMD_WRITE);
        run_read_s    = (state_q == ST_RUN) && (cmd_q == CMD_READ);
        beat_s        = run_write_s && wvalid_i[grant_idx_q] && mem_wready_i;
        mem_en_o      = beat_s;
        wready_o      = beat_s ? grant_q : '0;
        rvalid_o      = (run_read_s && mem_rvalid_i) ? grant_q : '0;
        rdata_o       = mem_rdata_i;
        mem_wdata_o   = req_wdata_s[grant_idx_q];
        mem_start_o   = start_q;
        mem_end_o     = end_q;
        mem_command_o = mem_cmd_q;
        mem_rst_o     = rst_i | mem_rst_q;
        grant_o       = grant_q;
        grant_idx_o   = grant_idx_q;
        done_o        = done_q;
        err_o         = err_q;
    end

endmodule

// File: tb/tb_aether_engine_mem_arbiter.sv
// Scoreboard bench for aether_engine_mem_arbiter with a behavioural model of
// the shared memory; expected events are queued by the stimulus thread.
module tb_aether_engine_mem_arbiter;
    import aether_mem_arb_pkg::*;

    localparam int NR = 3;
    localparam int IW = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic              req_a [NR];
    logic [1:0]        cmd_a [NR];
    logic [31:0]       st_a  [NR];
    logic [31:0]       en_a  [NR];
    logic [15:0]       wd_a  [NR];
    logic              wv_a  [NR];

    logic [NR-1:0]     req_v, wv_v;
    logic [2*NR-1:0]   cmd_v;
    logic [32*NR-1:0]  st_v, en_v;
    logic [16*NR-1:0]  wd_v;

    logic [NR-1:0]     grant_o, wready_o, rvalid_o, done_o, err_o;
    logic [IW-1:0]     grant_idx_o;
    logic [15:0]       rdata_o, mem_wdata_o;
    logic              mem_rst_o, mem_en_o;
    logic [1:0]        mem_command_o;
    logic [31:0]       mem_start_o, mem_end_o;

    logic              m_run = 1'b0, m_fin = 1'b0, m_wr = 1'b0, m_rv = 1'b0;
    logic [31:0]       m_addr = 32'd0, m_end = 32'd0;
    logic [15:0]       m_rd = 16'd0;
    logic [15:0]       marr [64];
    logic              m_wready;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_v[i]            = req_a[i];
            wv_v[i]             = wv_a[i];
            cmd_v[2*i +: 2]     = cmd_a[i];
            st_v[32*i +: 32]    = st_a[i];
            en_v[32*i +: 32]    = en_a[i];
            wd_v[16*i +: 16]    = wd_a[i];
        end
    end

    assign m_wready = m_run && m_wr;

    aether_engine_mem_arbiter #(.NumReq(NR), .ReqIdxW(IW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_v),
        .cmd_i          (cmd_v),
        .start_addr_i   (st_v),
        .end_addr_i     (en_v),
        .wdata_i        (wd_v),
        .wvalid_i       (wv_v),
        .grant_o        (grant_o),
        .grant_idx_o    (grant_idx_o),
        .wready_o       (wready_o),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .mem_rst_o      (mem_rst_o),
        .mem_en_o       (mem_en_o),
        .mem_command_o  (mem_command_o),
        .mem_start_o    (mem_start_o),
        .mem_end_o      (mem_end_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (m_rd),
        .mem_rvalid_i   (m_rv),
        .mem_wready_i   (m_wready),
        .mem_finished_i (m_fin),
        .mem_running_i  (m_run)
    );

    // Behavioural memory: latches a command, streams beats, holds finished until reset.
    always @(posedge clk_i) begin
        if (mem_rst_o) begin
            m_run <= 1'b0;
            m_fin <= 1'b0;
            m_rv  <= 1'b0;
        end else begin
            m_rv <= 1'b0;
            if (!m_run && !m_fin && (mem_command_o == 2'd1 || mem_command_o == 2'd2)) begin
                m_run  <= 1'b1;
                m_wr   <= (mem_command_o == 2'd1);
                m_addr <= mem_start_o;
                m_end  <= mem_end_o;
            end else if (m_run && m_wr) begin
                if (mem_en_o) begin
                    marr[m_addr[5:0]] <= mem_wdata_o;
                    if (m_addr == m_end) begin
                        m_run <= 1'b0;
                        m_fin <= 1'b1;
                    end else begin
                        m_addr <= m_addr + 32'd1;
                    end
                end
            end else if (m_run) begin
                m_rv <= 1'b1;
                m_rd <= marr[m_addr[5:0]];
                if (m_addr == m_end) begin
                    m_run <= 1'b0;
                    m_fin <= 1'b1;
                end else begin
                    m_addr <= m_addr + 32'd1;
                end
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
    } ev_t;

    ev_t q_grant[$], q_cmd[$], q_wbeat[$], q_rdata[$], q_done[$], q_err[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic ev_t ev(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
        ev_t e;
        e.idx = idx; e.a = a; e.b = b; e.c = c;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [NR-1:0] prev_grant = '0;

    // Monitor: pops the matching queue whenever the DUT presents an event.
    always @(negedge clk_i) begin
        ev_t e;
        check("grant_onehot0", {31'd0, $onehot0(grant_o)}, 32'd1);
        check("en_matches_wready", {31'd0, mem_en_o}, {31'd0, |wready_o});
        check("wready_without_wvalid", 32'(wready_o & ~wv_v), 32'd0);
        if (grant_o != '0 && prev_grant == '0) begin
            if (q_grant.size() == 0) check("grant_unexpected", 32'(grant_o), 32'd0);
            else begin
                e = q_grant.pop_front();
                check("grant_vec", 32'(grant_o), 32'd1 << e.idx);
                check("grant_idx", 32'(grant_idx_o), 32'(e.idx));
            end
        end
        prev_grant <= grant_o;
        if (mem_command_o != 2'd0) begin
            if (q_cmd.size() == 0) check("cmd_unexpected", 32'(mem_command_o), 32'd0);
            else begin
                e = q_cmd.pop_front();
                check("cmd_value", 32'(mem_command_o), 32'(e.c));
                check("cmd_start", mem_start_o, e.a);
                check("cmd_end", mem_end_o, e.b);
            end
        end
        if (wready_o != '0) begin
            if (q_wbeat.size() == 0) check("wbeat_unexpected", 32'(wready_o), 32'd0);
            else begin
                e = q_wbeat.pop_front();
                check("wbeat_vec", 32'(wready_o), 32'd1 << e.idx);
                check("wbeat_data", 32'(mem_wdata_o), e.a);
            end
        end
        if (rvalid_o != '0) begin
            if (q_rdata.size() == 0) check("rdata_unexpected", 32'(rvalid_o), 32'd0);
            else begin
                e = q_rdata.pop_front();
                check("rvalid_vec", 32'(rvalid_o), 32'd1 << e.idx);
                check("rdata_val", 32'(rdata_o), e.a);
            end
        end
        if (done_o != '0) begin
            if (q_done.size() == 0) check("done_unexpected", 32'(done_o), 32'd0);
            else begin
                e = q_done.pop_front();
                check("done_vec", 32'(done_o), 32'd1 << e.idx);
            end
        end
        if (err_o != '0) begin
            if (q_err.size() == 0) check("err_unexpected", 32'(err_o), 32'd0);
            else begin
                e = q_err.pop_front();
                check("err_vec", 32'(err_o), 32'd1 << e.idx);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives one requester through a full task until its done pulse.
    task automatic run_task(input int r, input logic [1:0] c, input logic [31:0] s,
                            input logic [31:0] e, input logic [15:0] dbase, input bit toggle);
        int beats = 0;
        int cyc   = 0;
        bit fin   = 1'b0;
        @(posedge clk_i); #1;
        req_a[r] = 1'b1; cmd_a[r] = c; st_a[r] = s; en_a[r] = e;
        wd_a[r] = dbase; wv_a[r] = (c == 2'd1);
        while (!fin) begin
            @(negedge clk_i);
            if (wready_o[r]) beats++;
            if (done_o[r]) fin = 1'b1;
            else if (cyc > 300) begin
                check("task_timeout", 32'(cyc), 32'd0);
                fin = 1'b1;
            end
            cyc++;
            @(posedge clk_i); #1;
            if (fin) begin
                req_a[r] = 1'b0; cmd_a[r] = 2'd0; wv_a[r] = 1'b0;
            end else begin
                wd_a[r] = dbase + 16'(beats);
                wv_a[r] = (c == 2'd1) && (!toggle || (cyc % 2 == 0));
            end
        end
        if (c == 2'd1) check("write_beats", 32'(beats), e - s + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int cyc;
        for (int i = 0; i < NR; i++) begin
            req_a[i] = 1'b0; cmd_a[i] = 2'd0; st_a[i] = 32'd0;
            en_a[i] = 32'd0; wd_a[i] = 16'd0; wv_a[i] = 1'b0;
        end
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_grant_idx", 32'(grant_idx_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_wready", 32'(wready_o), 32'd0);
        check("rst_mem_cmd", 32'(mem_command_o), 32'd0);
        check("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
        check("rst_mem_rst", {31'd0, mem_rst_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mem_rst_released", {31'd0, mem_rst_o}, 32'd0);

        // Single write, requester 0; rr_ptr becomes 1.
        q_grant.push_back(ev(0, 0, 0, 0));
        q_cmd.push_back(ev(0, 32'h10, 32'h13, 2'd1));
        for (int k = 0; k < 4; k++) q_wbeat.push_back(ev(0, 32'h10 + 32'(k), 0, 0));
        q_done.push_back(ev(0, 0, 0, 0));
        run_task(0, 2'd1, 32'h10, 32'h13, 16'h0010, 1'b0);
        cycles(4);
        check("t1_grant_released", 32'(grant_o), 32'd0);

        // Read back by requester 1; rr_ptr becomes 2.
        q_grant.push_back(ev(1, 0, 0, 0));
        q_cmd.push_back(ev(1, 32'h10, 32'h13, 2'd2));
        for (int k = 0; k < 4; k++) q_rdata.push_back(ev(1, 32'h10 + 32'(k), 0, 0));
        q_done.push_back(ev(1, 0, 0, 0));
        run_task(1, 2'd2, 32'h10, 32'h13, 16'h0000, 1'b0);
        cycles(4);

        // All three contend with rr_ptr=2: order 2, 0, 1; single-beat tasks.
        q_grant.push_back(ev(2, 0, 0, 0));
        q_grant.push_back(ev(0, 0, 0, 0));
        q_grant.push_back(ev(1, 0, 0, 0));
        q_cmd.push_back(ev(2, 32'h32, 32'h32, 2'd1));
        q_cmd.push_back(ev(0, 32'h30, 32'h30, 2'd1));
        q_cmd.push_back(ev(1, 32'h31, 32'h31, 2'd1));
        q_wbeat.push_back(ev(2, 32'hA2, 0, 0));
        q_wbeat.push_back(ev(0, 32'hA0, 0, 0));
        q_wbeat.push_back(ev(1, 32'hA1, 0, 0));
        q_done.push_back(ev(2, 0, 0, 0));
        q_done.push_back(ev(0, 0, 0, 0));
        q_done.push_back(ev(1, 0, 0, 0));
        fork
            run_task(0, 2'd1, 32'h30, 32'h30, 16'h00A0, 1'b0);
            run_task(1, 2'd1, 32'h31, 32'h31, 16'h00A1, 1'b0);
            run_task(2, 2'd1, 32'h32, 32'h32, 16'h00A2, 1'b0);
        join
        cycles(4);

        // Pair of reads with rr_ptr=2: wraps to 0 first, then 1.
        q_grant.push_back(ev(0, 0, 0, 0));
        q_grant.push_back(ev(1, 0, 0, 0));
        q_cmd.push_back(ev(0, 32'h30, 32'h32, 2'd2));
        q_cmd.push_back(ev(1, 32'h32, 32'h32, 2'd2));
        q_rdata.push_back(ev(0, 32'hA0, 0, 0));
        q_rdata.push_back(ev(0, 32'hA1, 0, 0));
        q_rdata.push_back(ev(0, 32'hA2, 0, 0));
        q_rdata.push_back(ev(1, 32'hA2, 0, 0));
        q_done.push_back(ev(0, 0, 0, 0));
        q_done.push_back(ev(1, 0, 0, 0));
        fork
            run_task(0, 2'd2, 32'h30, 32'h32, 16'h0000, 1'b0);
            run_task(1, 2'd2, 32'h32, 32'h32, 16'h0000, 1'b0);
        join
        cycles(4);

        // Invalid command: err pulse, no grant, no memory command.
        q_err.push_back(ev(0, 0, 0, 0));
        req_a[0] = 1'b1; cmd_a[0] = 2'd3;
        cycles(1);
        req_a[0] = 1'b0; cmd_a[0] = 2'd0;
        cycles(5);
        check("inv_no_grant", 32'(grant_o), 32'd0);
        check("inv_cmd_idle", 32'(mem_command_o), 32'd0);

        // Backpressured write, wvalid toggling; rr_ptr=2 wraps to 0, then 1.
        q_grant.push_back(ev(0, 0, 0, 0));
        q_cmd.push_back(ev(0, 32'h40, 32'h43, 2'd1));
        for (int k = 0; k < 4; k++) q_wbeat.push_back(ev(0, 32'hB0 + 32'(k), 0, 0));
        q_done.push_back(ev(0, 0, 0, 0));
        run_task(0, 2'd1, 32'h40, 32'h43, 16'h00B0, 1'b1);
        cycles(4);

        // Reset two beats into an 8-beat write by requester 1.
        q_grant.push_back(ev(1, 0, 0, 0));
        q_cmd.push_back(ev(1, 32'h20, 32'h27, 2'd1));
        q_wbeat.push_back(ev(1, 32'hC0, 0, 0));
        q_wbeat.push_back(ev(1, 32'hC1, 0, 0));
        req_a[1] = 1'b1; cmd_a[1] = 2'd1; st_a[1] = 32'h20; en_a[1] = 32'h27;
        wd_a[1] = 16'h00C0; wv_a[1] = 1'b1;
        beats = 0;
        cyc = 0;
        while (beats < 2 && cyc < 100) begin
            @(negedge clk_i);
            if (wready_o[1]) beats++;
            cyc++;
            @(posedge clk_i); #1;
            wd_a[1] = 16'h00C0 + 16'(beats);
        end
        check("rst_run_beats", 32'(beats), 32'd2);
        rst_i = 1'b1;
        wv_a[1] = 1'b0; req_a[1] = 1'b0; cmd_a[1] = 2'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_grant", 32'(grant_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_mem_rst", {31'd0, mem_rst_o}, 32'd1);
        check("midrst_wready", 32'(wready_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        cycles(2);

        // After reset rr_ptr=0: requester 0 beats requester 2.
        q_grant.push_back(ev(0, 0, 0, 0));
        q_grant.push_back(ev(2, 0, 0, 0));
        q_cmd.push_back(ev(0, 32'h40, 32'h41, 2'd2));
        q_cmd.push_back(ev(2, 32'h42, 32'h43, 2'd2));
        q_rdata.push_back(ev(0, 32'hB0, 0, 0));
        q_rdata.push_back(ev(0, 32'hB1, 0, 0));
        q_rdata.push_back(ev(2, 32'hB2, 0, 0));
        q_rdata.push_back(ev(2, 32'hB3, 0, 0));
        q_done.push_back(ev(0, 0, 0, 0));
        q_done.push_back(ev(2, 0, 0, 0));
        fork
            run_task(0, 2'd2, 32'h40, 32'h41, 16'h0000, 1'b0);
            run_task(2, 2'd2, 32'h42, 32'h43, 16'h0000, 1'b0);
        join
        cycles(6);

        check("left_grant", 32'(q_grant.size()), 32'd0);
        check("left_cmd", 32'(q_cmd.size()), 32'd0);
        check("left_wbeat", 32'(q_wbeat.size()), 32'd0);
        check("left_rdata", 32'(q_rdata.size()), 32'd0);
        check("left_done", 32'(q_done.size()), 32'd0);
        check("left_err", 32'(q_err.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
